pll_reconf_sequencer: RTL
=========================

Name: pll_reconf_sequencer

Overview:
Control-clock-domain sequencer for the HDMI pixel PLL reconfiguration path. It watches the requested video mode code from the I2C slave and drives the ROM-load and reconfig handshakes of the PLL reconfiguration core. It then supervises PLL relock with timeout and retry. While a sequence is in flight it holds HDMI output blanked (gates ADV7513 output_ready), and it publishes the committed mode and error status.

Parameters:
LOCK_TIMEOUT, 32'd2_000_000, control_clock cycles to wait for pll_locked after reconfig.
BUSY_START_WAIT, 5'd16, cycles allowed for busy to rise after a load/reconfig pulse before the step is treated as complete.
MAX_RETRIES, 2'd2, lock-timeout retries before entering ERROR.
ARESET_CYCLES, 4'd8, pll_areset pulse length on retry.

Ports:
clock  in  1  control_clock
reset  in  1  asynchronous, active-high
mode_in  in  8  requested mode code (reconf_data); level, may change any time
busy  in  1  reconfig core busy
pll_locked  in  1  HDMI PLL locked; asynchronous, double-flopped internally
write_from_rom  out  1  one-cycle pulse: load scan chain from ROM
reconfig  out  1  one-cycle pulse: apply scan chain to PLL
pll_areset  out  1  PLL reset request on retry
hold_output  out  1  high = keep HDMI output inactive
current_mode  out  8  last committed mode code
done  out  1  one-cycle pulse on successful lock after a sequence
error  out  1  level; retries exhausted
state_out  out  3  state encoding for debug/I2C readback

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE, boot_pending=1, current_mode=8'h00, target=8'h00.
  - All pulse outputs 0, error=0, retry_cnt=0, hold_output=1.
- State encodings: IDLE=0, LOAD=1, WAIT_LOAD=2, RECONF=3, WAIT_RECONF=4, WAIT_LOCK=5, ARESET=6, ERROR=7.
- Change detect: pending = boot_pending OR (mode_in != target). The comparison is evaluated every cycle in all states.
- IDLE:
  - If pending: latch target<=mode_in, clear boot_pending, hold_output<=1, retry_cnt<=0, go LOAD.
  - Otherwise hold_output<=0, but only when the synchronized lock is 1 and error=0.
- LOAD: only entered or left with busy=0; if busy=1, stay. Assert write_from_rom for exactly 1 cycle, go WAIT_LOAD.
- WAIT_LOAD:
  - A 5-bit counter starts at 0. Once busy has been seen high, step completes on busy=0.
  - If busy is never seen high within BUSY_START_WAIT cycles, step completes at the counter limit.
  - Step completion -> RECONF.
- RECONF: same rules as LOAD, but pulses reconfig. -> WAIT_RECONF.
- WAIT_RECONF: same completion rule as WAIT_LOAD. -> WAIT_LOCK, lock counter cleared.
- WAIT_LOCK:
  - On synchronized lock=1: current_mode<=target, done pulse 1 cycle, error<=0, go IDLE.
  - On lock counter == LOCK_TIMEOUT-1:
    - retry_cnt < MAX_RETRIES: retry_cnt++, go ARESET.
    - retry_cnt == MAX_RETRIES: error<=1, go ERROR.
- ARESET: pll_areset=1 for ARESET_CYCLES cycles, then go LOAD; the whole sequence reruns.
- ERROR: hold_output=1, error=1. Any mode_in != target restarts from IDLE-entry behaviour; error clears on the next successful lock.
- Mode change mid-sequence (LOAD..ARESET):
  - The current step always finishes; pulses are never truncated and never issued twice.
  - On reaching WAIT_LOCK, if mode_in != target, skip lock wait and restart at LOAD with target<=mode_in, retry_cnt<=0. done is not pulsed and current_mode is not updated.
- Lock loss in IDLE (sync lock 0): hold_output<=1, no reconfig issued; hold_output drops again when lock returns.
- Reset asserted mid-operation: outputs return to reset values immediately, including pulse outputs forced 0. After release, the boot sequence runs with target=mode_in.
- Counters saturate, never wrap. The lock counter is 32-bit and is cleared on every WAIT_LOCK entry.
- Output timing: write_from_rom and reconfig are never high in the same cycle, and never while busy=1.

Test Plan:
- Boot sequence: release reset with mode_in=8'h01, busy model busy 1 cycle after pulse for 20 cycles, lock 100 cycles after reconfig -> one write_from_rom, one reconfig, done pulse, current_mode=8'h01, hold_output 1->0, state_out=0.
- Mode change in IDLE: mode_in 01->02 -> hold_output=1 within 1 cycle; exactly one load/reconfig pair; current_mode=8'h02 after lock.
- Mode change during WAIT_LOAD: mode_in 02->03 -> sequence finishes its reconfig, then restarts at LOAD. Total 2 write_from_rom and 2 reconfig pulses; single done; current_mode=8'h03, never 02.
- Lock timeout (LOCK_TIMEOUT=1000, lock held 0): three sequences separated by two pll_areset pulses of 8 cycles, then error=1, state_out=7, hold_output=1. Then mode_in change plus lock -> error=0, done.
- Busy never asserts: write_from_rom pulse, then reconfig exactly BUSY_START_WAIT cycles later -> sequence continues, no hang.
- Async reset asserted in WAIT_RECONF -> all outputs at reset values in the same cycle; after release, boot sequence reruns.

Source files
------------

// File: rtl/pll_reconf_if.sv
// Handshake bundle between the PLL reconfiguration sequencer and its surroundings
// (mode source, reconfig core, PLL lock, HDMI output gating, status readback).
interface pll_reconf_if;
  logic [7:0] mode_in;
  logic       busy;
  logic       pll_locked;
  logic       write_from_rom;
  logic       reconfig;
  logic       pll_areset;
  logic       hold_output;
  logic [7:0] current_mode;
  logic       done;
  logic       error;
  logic [2:0] state_out;

  modport master (
    input  mode_in, busy, pll_locked,
    output write_from_rom, reconfig, pll_areset, hold_output,
           current_mode, done, error, state_out
  );

  modport slave (
    output mode_in, busy, pll_locked,
    input  write_from_rom, reconfig, pll_areset, hold_output,
           current_mode, done, error, state_out
  );
endinterface

// File: rtl/pll_reconf_sequencer.sv
// Sequences ROM-load / reconfig handshakes for the HDMI pixel PLL on mode changes,
// supervises relock with timeout and areset retries, and gates HDMI output meanwhile.
module pll_reconf_sequencer #(
  parameter logic [31:0] LOCK_TIMEOUT    = 32'd2_000_000,
  parameter logic [4:0]  BUSY_START_WAIT = 5'd16,
  parameter logic [1:0]  MAX_RETRIES     = 2'd2,
  parameter logic [3:0]  ARESET_CYCLES   = 4'd8
) (
  input  logic         clock,
  input  logic         reset,
  pll_reconf_if.master bus
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    WAIT_LOAD   = 3'd2,
    RECONF      = 3'd3,
    WAIT_RECONF = 3'd4,
    WAIT_LOCK   = 3'd5,
    ARESET      = 3'd6,
    ERROR       = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        boot_pending_q, boot_pending_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  current_mode_q, current_mode_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  retry_q, retry_d;
  logic [4:0]  wait_cnt_q, wait_cnt_d;
  logic        busy_seen_q, busy_seen_d;
  logic [31:0] lock_cnt_q, lock_cnt_d;
  logic [3:0]  areset_cnt_q, areset_cnt_d;
  logic        lock_meta_q, lock_sync_q;

  logic        mode_changed, pending, busy_seen_now, step_done;
  logic        load_pulse, reconf_pulse;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= bus.pll_locked;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      boot_pending_q <= 1'b1;
      target_q       <= '0;
      current_mode_q <= '0;
      hold_q         <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      retry_q        <= '0;
      wait_cnt_q     <= '0;
      busy_seen_q    <= 1'b0;
      lock_cnt_q     <= '0;
      areset_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      boot_pending_q <= boot_pending_d;
      target_q       <= target_d;
      current_mode_q <= current_mode_d;
      hold_q         <= hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
      retry_q        <= retry_d;
      wait_cnt_q     <= wait_cnt_d;
      busy_seen_q    <= busy_seen_d;
      lock_cnt_q     <= lock_cnt_d;
      areset_cnt_q   <= areset_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    boot_pending_d = boot_pending_q;
    target_d       = target_q;
    current_mode_d = current_mode_q;
    hold_d         = hold_q;
    done_d         = 1'b0;
    error_d        = error_q;
    retry_d        = retry_q;
    wait_cnt_d     = wait_cnt_q;
    busy_seen_d    = busy_seen_q;
    lock_cnt_d     = lock_cnt_q;
    areset_cnt_d   = areset_cnt_q;
    load_pulse     = 1'b0;
    reconf_pulse   = 1'b0;

    mode_changed  = (bus.mode_in != target_q);
    pending       = boot_pending_q | mode_changed;
    busy_seen_now = busy_seen_q | bus.busy;
    // wait_cnt counts cycles since the pulse (pulse cycle = 0), so the next
    // pulse lands exactly BUSY_START_WAIT cycles after the previous one.
    step_done     = busy_seen_now ? !bus.busy : (wait_cnt_q == BUSY_START_WAIT - 5'd1);

    case (state_q)
      IDLE: begin
        if (pending) begin
          target_d       = bus.mode_in;
          boot_pending_d = 1'b0;
          hold_d         = 1'b1;
          retry_d        = '0;
          state_d        = LOAD;
        end else begin
          hold_d = !(lock_sync_q && !error_q);
        end
      end
      LOAD, RECONF: begin
        if (!bus.busy) begin
          load_pulse   = (state_q == LOAD);
          reconf_pulse = (state_q == RECONF);
          wait_cnt_d   = 5'd1;
          busy_seen_d  = 1'b0;
          state_d      = (state_q == LOAD) ? WAIT_LOAD : WAIT_RECONF;
        end
      end
      WAIT_LOAD, WAIT_RECONF: begin
        busy_seen_d = busy_seen_now;
        if (step_done) begin
          lock_cnt_d = '0;
          state_d    = (state_q == WAIT_LOAD) ? RECONF : WAIT_LOCK;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 5'd1;
        end
      end
      WAIT_LOCK: begin
        if (mode_changed) begin
          target_d = bus.mode_in;
          retry_d  = '0;
          state_d  = LOAD;
        end else if (lock_sync_q) begin
          current_mode_d = target_q;
          done_d         = 1'b1;
          error_d        = 1'b0;
          state_d        = IDLE;
        end else if (lock_cnt_q == LOCK_TIMEOUT - 32'd1) begin
          if (retry_q < MAX_RETRIES) begin
            retry_d      = retry_q + 2'd1;
            areset_cnt_d = '0;
            state_d      = ARESET;
          end else begin
            error_d = 1'b1;
            state_d = ERROR;
          end
        end else if (lock_cnt_q != '1) begin
          lock_cnt_d = lock_cnt_q + 32'd1;
        end
      end
      ARESET: begin
        if (areset_cnt_q == ARESET_CYCLES - 4'd1) begin
          state_d = LOAD;
        end else begin
          areset_cnt_d = areset_cnt_q + 4'd1;
        end
      end
      ERROR: begin
        hold_d  = 1'b1;
        error_d = 1'b1;
        if (mode_changed) begin
          target_d = bus.mode_in;
          retry_d  = '0;
          state_d  = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.write_from_rom = load_pulse;
  assign bus.reconfig       = reconf_pulse;
  assign bus.pll_areset     = (state_q == ARESET);
  assign bus.hold_output    = hold_q;
  assign bus.current_mode   = current_mode_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.state_out      = state_q;

endmodule
